// File: rtl/cfg_frame_loader.sv
// cfg_frame_loader
// Parses framed parameter packets from the UART receive byte stream:
//   HDR, b0[15:8], b0[7:0], b1[15:8], b1[7:0], vr, CHK, TERM
// Each frame is checked by its modulo-256 payload sum and its terminator.
// A validated set of b0/b1/vr waits in the pending registers. It is applied
// to the control loop only on a loop_tick, so one control update never sees
// a mix of old and new gains.
module cfg_frame_loader #(
  parameter int unsigned TIMEOUT_CYC = 60000,
  parameter logic [7:0]  HDR         = 8'hA5,
  parameter logic [7:0]  TERM        = 8'hF7,
  parameter logic [15:0] B0_RST      = 16'd20,
  parameter logic [15:0] B1_RST      = 16'd5,
  parameter logic [7:0]  VR_RST      = 8'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        loop_tick,
  output logic [15:0] b0,
  output logic [15:0] b1,
  output logic [7:0]  vr,
  output logic        cfg_update,
  output logic        frame_err,
  output logic [7:0]  err_cnt,
  output logic        busy,
  output logic        pending
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PAYLOAD,
    S_CHK,
    S_TERM
  } state_t;

  // The timeout fires when the idle counter already holds this value and
  // still no byte arrives.
  localparam logic [19:0] TMO_LAST = 20'(TIMEOUT_CYC - 1);

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  idx;
  logic [7:0]  sum;
  logic [7:0]  shadow [5];
  logic [19:0] tmo_cnt;
  logic        tmo_hit;
  logic        hdr_start;
  logic        err_evt;
  logic        validate;

  logic [15:0] pend_b0;
  logic [15:0] pend_b1;
  logic [7:0]  pend_vr;

  // A header byte seen while idle opens a new frame.
  assign hdr_start = (state == S_IDLE) && rx_valid && (rx_data == HDR);

  // Inter-byte silence reached the limit inside a frame.
  assign tmo_hit = (state != S_IDLE) && !rx_valid && (tmo_cnt == TMO_LAST);

  assign busy = (state != S_IDLE);

  // Parser state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values; blocking here would create
      // order-dependent races between always blocks.
      state <= state_nxt;
    end
  end

  // Next-state decode plus the error/validate events for this cycle.
  always_comb begin
    // NOTE: every output of this block is given a default first; any path
    // that skipped an assignment would otherwise infer a latch.
    state_nxt = state;
    err_evt   = 1'b0;
    validate  = 1'b0;
    unique case (state)
      S_IDLE: begin
        // Anything except the header is dropped silently.
        if (hdr_start) state_nxt = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        if (rx_valid && (idx == 3'd4)) state_nxt = S_CHK;
      end
      S_CHK: begin
        if (rx_valid) begin
          if (rx_data == sum) begin
            state_nxt = S_TERM;
          end else begin
            err_evt   = 1'b1;
            state_nxt = S_IDLE;
          end
        end
      end
      S_TERM: begin
        // A wrong terminator is consumed here. It is not re-examined as a
        // possible header.
        if (rx_valid) begin
          state_nxt = S_IDLE;
          if (rx_data == TERM) validate = 1'b1;
          else                 err_evt  = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (tmo_hit) begin
      err_evt   = 1'b1;
      state_nxt = S_IDLE;
    end
  end

  // Inter-byte timeout counter. It is held at zero while idle and restarts
  // on every received byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt <= '0;
    end else if ((state == S_IDLE) || rx_valid || tmo_hit) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 20'd1;
    end
  end

  // Payload capture into the shadow bytes and the running checksum.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx <= '0;
      sum <= '0;
      // NOTE: the small shadow array is reset along with the rest, so no
      // byte from before reset can ever be observed afterwards.
      for (int i = 0; i < 5; i++) shadow[i] <= '0;
    end else if (hdr_start) begin
      idx <= '0;
      sum <= '0;
    end else if ((state == S_PAYLOAD) && rx_valid) begin
      shadow[idx] <= rx_data;
      sum         <= sum + rx_data;
      idx         <= idx + 3'd1;
    end
  end

  // Pending hold and commit to the active set on loop_tick. Latest wins: a
  // newer frame replaces a pending one. A frame validated on the tick edge
  // itself goes straight to the outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_b0    <= '0;
      pend_b1    <= '0;
      pend_vr    <= '0;
      pending    <= 1'b0;
      b0         <= B0_RST;
      b1         <= B1_RST;
      vr         <= VR_RST;
      cfg_update <= 1'b0;
    end else begin
      cfg_update <= 1'b0;
      if (loop_tick && validate) begin
        b0         <= {shadow[0], shadow[1]};
        b1         <= {shadow[2], shadow[3]};
        vr         <= shadow[4];
        pending    <= 1'b0;
        cfg_update <= 1'b1;
      end else if (loop_tick && pending) begin
        b0         <= pend_b0;
        b1         <= pend_b1;
        vr         <= pend_vr;
        pending    <= 1'b0;
        cfg_update <= 1'b1;
      end else if (validate) begin
        pend_b0 <= {shadow[0], shadow[1]};
        pend_b1 <= {shadow[2], shadow[3]};
        pend_vr <= shadow[4];
        pending <= 1'b1;
      end
    end
  end

  // Registered error pulse and saturating rejected-frame counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_err <= 1'b0;
      err_cnt   <= '0;
    end else begin
      frame_err <= err_evt;
      if (err_evt && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_cfg_frame_loader.sv
// Testbench for cfg_frame_loader. It runs directed steps and then randomized
// traffic. Every cycle is compared against a byte-queue reference model that
// is kept inside the bench.
module tb_cfg_frame_loader;

  localparam int          T      = 40;
  localparam logic [7:0]  HDR_B  = 8'hA5;
  localparam logic [7:0]  TERM_B = 8'hF7;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        loop_tick;
  logic [15:0] b0;
  logic [15:0] b1;
  logic [7:0]  vr;
  logic        cfg_update;
  logic        frame_err;
  logic [7:0]  err_cnt;
  logic        busy;
  logic        pending;

  always #5 clk = ~clk;

  cfg_frame_loader #(.TIMEOUT_CYC(T)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .loop_tick  (loop_tick),
    .b0         (b0),
    .b1         (b1),
    .vr         (vr),
    .cfg_update (cfg_update),
    .frame_err  (frame_err),
    .err_cnt    (err_cnt),
    .busy       (busy),
    .pending    (pending)
  );

  int    checks = 0;
  int    errors = 0;
  string phase  = "reset";

  // Reference model state.
  logic [7:0]  frm [$];
  int          idle_cnt;
  logic        m_pend;
  logic [15:0] m_pb0, m_pb1, m_b0, m_b1;
  logic [7:0]  m_pvr, m_vr;
  logic        m_upd, m_err;
  int          m_errcnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    frm.delete();
    idle_cnt = 0;
    m_pend   = 1'b0;
    m_pb0    = '0;
    m_pb1    = '0;
    m_pvr    = '0;
    m_b0     = 16'd20;
    m_b1     = 16'd5;
    m_vr     = 8'd0;
    m_upd    = 1'b0;
    m_err    = 1'b0;
    m_errcnt = 0;
  endtask

  // The model collects the bytes of the current frame and judges them as a
  // whole once the checksum byte or the terminator byte arrives.
  task automatic model_edge(input logic v, input logic [7:0] d, input logic tk);
    logic        vld;
    logic [15:0] nb0, nb1;
    logic [7:0]  nvr, s;
    vld = 1'b0; nb0 = '0; nb1 = '0; nvr = '0;
    m_upd = 1'b0;
    m_err = 1'b0;
    if (frm.size() != 0) begin
      if (v) begin
        frm.push_back(d);
        idle_cnt = 0;
        if (frm.size() == 7) begin
          s = '0;
          for (int i = 1; i <= 5; i++) s = s + frm[i];
          if (frm[6] != s) begin
            m_err = 1'b1;
            frm.delete();
          end
        end else if (frm.size() == 8) begin
          if (frm[7] == TERM_B) begin
            vld = 1'b1;
            nb0 = {frm[1], frm[2]};
            nb1 = {frm[3], frm[4]};
            nvr = frm[5];
          end else begin
            m_err = 1'b1;
          end
          frm.delete();
        end
      end else begin
        idle_cnt++;
        if (idle_cnt == T) begin
          m_err = 1'b1;
          frm.delete();
        end
      end
    end else if (v && d == HDR_B) begin
      frm.push_back(d);
      idle_cnt = 0;
    end
    if (tk && vld) begin
      m_b0 = nb0; m_b1 = nb1; m_vr = nvr; m_upd = 1'b1; m_pend = 1'b0;
    end else if (tk && m_pend) begin
      m_b0 = m_pb0; m_b1 = m_pb1; m_vr = m_pvr; m_upd = 1'b1; m_pend = 1'b0;
    end else if (vld) begin
      m_pb0 = nb0; m_pb1 = nb1; m_pvr = nvr; m_pend = 1'b1;
    end
    if (m_err && m_errcnt < 255) m_errcnt++;
  endtask

  // One clock: drive inputs, clock the edge, update the model, compare all outputs.
  task automatic step(input logic v, input logic [7:0] d, input logic tk);
    rx_valid  = v;
    rx_data   = d;
    loop_tick = tk;
    @(posedge clk);
    #1;
    model_edge(v, d, tk);
    rx_valid  = 1'b0;
    loop_tick = 1'b0;
    check(phase,
          {12'd0, b0, b1, vr, cfg_update, frame_err, err_cnt, busy, pending},
          {12'd0, m_b0, m_b1, m_vr, m_upd, m_err, 8'(m_errcnt), (frm.size() != 0), m_pend});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic send_bytes(input logic [7:0] by [8], input int nb, input int gap,
                            input bit tick_last, input bit rnd_tick);
    logic tk;
    for (int i = 0; i < nb; i++) begin
      tk = (tick_last && i == nb - 1) || (rnd_tick && ($urandom_range(0, 3) == 0));
      step(1'b1, by[i], tk);
      if (i < nb - 1) for (int g = 0; g < gap; g++) step(1'b0, 8'h00, 1'b0);
    end
  endtask

  task automatic send_frame(input logic [15:0] fb0, input logic [15:0] fb1, input logic [7:0] fvr,
                            input logic [7:0] chk_flip, input logic [7:0] term, input int gap,
                            input bit tick_last, input bit rnd_tick);
    logic [7:0] by [8];
    by[0] = HDR_B;
    by[1] = fb0[15:8];
    by[2] = fb0[7:0];
    by[3] = fb1[15:8];
    by[4] = fb1[7:0];
    by[5] = fvr;
    by[6] = (by[1] + by[2] + by[3] + by[4] + by[5]) ^ chk_flip;
    by[7] = term;
    send_bytes(by, 8, gap, tick_last, rnd_tick);
  endtask

  initial begin
    logic [7:0] by [8];
    int lat;
    int upd_seen;

    rst = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; loop_tick = 1'b0;
    model_reset();
    #12;
    check("reset_values", {12'd0, b0, b1, vr, cfg_update, frame_err, err_cnt, busy, pending},
          {12'd0, 16'd20, 16'd5, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0});
    @(negedge clk);
    rst = 1'b1;

    // Ten ticks with no traffic.
    phase = "idle_ticks";
    upd_seen = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 8'h00, 1'b1);
      if (cfg_update) upd_seen++;
      idle(2);
    end
    check("idle_ticks_no_update", upd_seen, 0);

    // A valid frame, held pending for 100 cycles, then committed.
    phase = "basic_frame";
    by = '{8'hA5, 8'h00, 8'h32, 8'h00, 8'h0A, 8'h64, 8'hA0, 8'hF7};
    send_bytes(by, 8, 0, 1'b0, 1'b0);
    check("basic_pending", pending, 1'b1);
    idle(100);
    check("basic_still_pending", {b0, pending}, {16'd20, 1'b1});
    step(1'b0, 8'h00, 1'b1);
    check("basic_commit", {b0, b1, vr, cfg_update, pending},
          {16'h0032, 16'h000A, 8'h64, 1'b1, 1'b0});
    step(1'b0, 8'h00, 1'b0);
    check("basic_update_one_cycle", cfg_update, 1'b0);

    // Bad checksum, then bad terminator.
    phase = "bad_chk";
    by = '{8'hA5, 8'h00, 8'h32, 8'h00, 8'h0A, 8'h11, 8'hA1, 8'hF7};
    send_bytes(by, 8, 0, 1'b0, 1'b0);
    check("bad_chk_state", {err_cnt, pending, vr}, {8'd1, 1'b0, 8'h64});
    phase = "bad_term";
    by = '{8'hA5, 8'h00, 8'h32, 8'h00, 8'h0A, 8'h64, 8'hA0, 8'hF6};
    send_bytes(by, 8, 0, 1'b0, 1'b0);
    check("bad_term_state", {err_cnt, pending, b0}, {8'd2, 1'b0, 16'h0032});

    // Truncated frame followed by silence.
    phase = "timeout";
    by = '{8'hA5, 8'h00, 8'h32, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_bytes(by, 3, 0, 1'b0, 1'b0);
    lat = -1;
    for (int i = 1; i <= T + 10; i++) begin
      step(1'b0, 8'h00, 1'b0);
      if (frame_err && lat < 0) lat = i;
    end
    check("timeout_latency", lat, T);
    check("timeout_state", {busy, err_cnt}, {1'b0, 8'd3});
    phase = "after_timeout";
    send_frame(16'h1234, 16'h0056, 8'h78, 8'h00, TERM_B, 0, 1'b0, 1'b0);
    check("after_timeout_pending", pending, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    check("after_timeout_commit", {b0, b1, vr}, {16'h1234, 16'h0056, 8'h78});

    // Gaps just short of the timeout keep the frame alive.
    phase = "slow_frame";
    send_frame(16'h0101, 16'h0202, 8'h33, 8'h00, TERM_B, T - 1, 1'b0, 1'b0);
    check("slow_frame_pending", {pending, err_cnt}, {1'b1, 8'd3});
    step(1'b0, 8'h00, 1'b1);

    // Latest wins.
    phase = "latest_wins";
    send_frame(16'h0011, 16'h0022, 8'h40, 8'h00, TERM_B, 0, 1'b0, 1'b0);
    send_frame(16'h0033, 16'h0044, 8'h50, 8'h00, TERM_B, 0, 1'b0, 1'b0);
    upd_seen = 0;
    step(1'b0, 8'h00, 1'b1);
    if (cfg_update) upd_seen++;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 8'h00, 1'b1);
      if (cfg_update) upd_seen++;
    end
    check("latest_wins_updates", upd_seen, 1);
    check("latest_wins_vals", {b0, b1, vr, err_cnt}, {16'h0033, 16'h0044, 8'h50, 8'd3});

    // Terminator on the same edge as loop_tick.
    phase = "term_with_tick";
    send_frame(16'h0A0B, 16'h0C0D, 8'h0E, 8'h00, TERM_B, 0, 1'b1, 1'b0);
    check("term_tick_commit", {pending, cfg_update, vr, b0}, {1'b0, 1'b1, 8'h0E, 16'h0A0B});
    step(1'b0, 8'h00, 1'b1);
    check("term_tick_single", cfg_update, 1'b0);

    // Reset with a set pending and a partial frame in flight.
    phase = "mid_reset";
    send_frame(16'h7777, 16'h8888, 8'h99, 8'h00, TERM_B, 0, 1'b0, 1'b0);
    by = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h00, 8'h00};
    send_bytes(by, 5, 0, 1'b0, 1'b0);
    rst = 1'b0;
    #2;
    check("mid_reset_values", {12'd0, b0, b1, vr, cfg_update, frame_err, err_cnt, busy, pending},
          {12'd0, 16'd20, 16'd5, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0});
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, 8'h00, 1'b1);
    check("mid_reset_no_commit", {cfg_update, vr}, {1'b0, 8'd0});
    idle(3);

    // Saturation of the error counter.
    phase = "saturate";
    for (int i = 0; i < 256; i++) begin
      by = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h00, 8'h00};
      send_bytes(by, 7, 0, 1'b0, 1'b0);
    end
    check("err_cnt_saturated", err_cnt, 8'd255);

    // Randomized traffic.
    phase = "random";
    for (int n = 0; n < 200; n++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind <= 5) begin
        send_frame(16'($urandom), 16'($urandom), 8'($urandom), 8'h00, TERM_B,
                   $urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'b1);
      end else if (kind == 6) begin
        send_frame(16'($urandom), 16'($urandom), 8'($urandom), 8'($urandom_range(1, 255)),
                   TERM_B, $urandom_range(0, 2), 1'b0, 1'b1);
      end else if (kind == 7) begin
        send_frame(16'($urandom), 16'($urandom), 8'($urandom), 8'h00,
                   8'($urandom_range(0, 255)) ^ 8'h01, 0, 1'b0, 1'b1);
      end else if (kind == 8) begin
        for (int i = 0; i < 4; i++) step(1'b1, 8'($urandom), 1'($urandom_range(0, 3) == 0));
      end else begin
        for (int i = 0; i < 8; i++) by[i] = 8'($urandom);
        by[0] = HDR_B;
        send_bytes(by, $urandom_range(1, 5), 0, 1'b0, 1'b1);
        idle(T + 2);
      end
      for (int i = $urandom_range(0, 4); i > 0; i--) step(1'b0, 8'h00, 1'($urandom_range(0, 3) == 0));
    end
    idle(T + 2);
    step(1'b0, 8'h00, 1'b1);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
